// File: rtl/nn_layer_scheduler.sv
// Layer sequencer: loads an input vector, runs each layer over a shared req/ack port while
// ping-ponging activations between two buffers, then streams the final vector out.
module nn_layer_scheduler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FANIN      = 2,
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned AW         = (FANIN > 1) ? $clog2(FANIN) : 1,
    parameter int unsigned LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             layer_req_o,
    output logic [LW-1:0]    layer_sel_o,
    input  logic             layer_ack_i,
    input  logic             rd_trig_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StDrain} state_e;

    localparam logic [AW-1:0] LastIdx   = AW'(FANIN - 1);
    localparam logic [LW-1:0] LastLayer = LW'(NUM_LAYERS - 1);

    state_e           state_q, state_d;
    logic             src_q, src_d;  // 0: A is the read buffer, 1: B is
    logic [AW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    layer_sel_q, layer_sel_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WIDTH-1:0] buf_a_q [FANIN];
    logic [WIDTH-1:0] buf_b_q [FANIN];

    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] src_word, drain_word;

    // Indices beyond FANIN only exist for non-power-of-two FANIN; they read as zero.
    assign rd_ok = 32'(rd_addr_i) < FANIN;
    assign wr_ok = 32'(wr_addr_i) < FANIN;

    always_comb begin
        src_word = '0;
        if (rd_ok) begin
            src_word = src_q ? buf_b_q[rd_addr_i] : buf_a_q[rd_addr_i];
        end
    end

    assign drain_word = src_q ? buf_b_q[idx_q] : buf_a_q[idx_q];

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        idx_d       = idx_q;
        layer_sel_d = layer_sel_q;
        done_d      = 1'b0;
        rd_data_d   = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StLoad;
                    src_d       = 1'b0;
                    idx_d       = '0;
                    layer_sel_d = '0;
                end
            end
            StLoad: begin
                if (in_valid_i) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StRun: begin
                state_d = StWait;
            end
            StWait: begin
                if (rd_trig_i) begin
                    rd_data_d = src_word;
                end
                if (layer_ack_i) begin
                    src_d = ~src_q;
                    if (layer_sel_q == LastLayer) begin
                        state_d = StDrain;
                        idx_d   = '0;
                    end else begin
                        layer_sel_d = layer_sel_q + 1'b1;
                        state_d     = StRun;
                    end
                end
            end
            StDrain: begin
                if (out_ready_i) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            src_q       <= 1'b0;
            idx_q       <= '0;
            layer_sel_q <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            idx_q       <= idx_d;
            layer_sel_q <= layer_sel_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Layer writes always land in the non-source buffer, so the src flip on ack
    // cannot redirect a write issued in the same cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == StLoad && in_valid_i) begin
            buf_a_q[idx_q] <= in_data_i;
        end
        if (state_q == StWait && wr_en_i && wr_ok) begin
            if (src_q) begin
                buf_a_q[wr_addr_i] <= wr_data_i;
            end else begin
                buf_b_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign in_ready_o  = (state_q == StLoad);
    assign layer_req_o = (state_q == StWait);
    assign layer_sel_o = layer_sel_q;
    assign rd_data_o   = rd_data_q;
    assign out_valid_o = (state_q == StDrain);
    assign out_data_o  = (state_q == StDrain) ? drain_word : '0;

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Scoreboard bench for nn_layer_scheduler: expected outputs are queued at stimulus time from
// a vector-level model (input plus per-layer offsets) and popped by an output monitor.
module tb_nn_layer_scheduler;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned FANIN      = 2;
    localparam int unsigned NUM_LAYERS = 2;
    localparam int unsigned AW         = 1;
    localparam int unsigned LW         = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             layer_req;
    logic [LW-1:0]    layer_sel;
    logic             layer_ack = 1'b0;
    logic             rd_trig = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;

    nn_layer_scheduler #(
        .WIDTH(WIDTH), .FANIN(FANIN), .NUM_LAYERS(NUM_LAYERS), .AW(AW), .LW(LW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .layer_req_o(layer_req), .layer_sel_o(layer_sel), .layer_ack_i(layer_ack),
        .rd_trig_i(rd_trig), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    bit               last_q[$];
    bit               pend_done = 1'b0;
    int               done_cnt  = 0;
    int               exp_done  = 0;

    logic [WIDTH-1:0] in_vec [FANIN];
    logic [WIDTH-1:0] k_vec  [NUM_LAYERS];
    logic [WIDTH-1:0] cur    [FANIN];
    logic [WIDTH-1:0] nxt    [FANIN];
    logic [WIDTH-1:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Output monitor: pops on every accepted word and expects done one cycle after the last.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_done) begin
                check("done_pulse", {31'b0, done}, 32'd1);
                check("busy_falls_with_done", {31'b0, busy}, 32'd0);
                if (done) done_cnt++;
                pend_done = 1'b0;
            end else if (done) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'b0, out_valid}, 32'd0);
                end else begin
                    logic [WIDTH-1:0] e;
                    bit               l;
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    check("out_data", {24'b0, out_data}, {24'b0, e});
                    if (l) pend_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Final activation = input plus the sum of every layer's offset, modulo 2^WIDTH.
    task automatic push_expected();
        for (int i = 0; i < FANIN; i++) begin
            logic [WIDTH-1:0] v;
            v = in_vec[i];
            for (int l = 0; l < NUM_LAYERS; l++) v = v + k_vec[l];
            exp_q.push_back(v);
            last_q.push_back(i == FANIN - 1);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic load_vec(input bit junk);
        for (int i = 0; i < FANIN; i++) begin
            repeat (int'($urandom_range(0, 2))) begin
                if (junk) begin
                    layer_ack = 1'b1;
                    start     = 1'b1;
                end
                tick();
                layer_ack = 1'b0;
                start     = 1'b0;
                check("in_ready_hold", {31'b0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data  = in_vec[i];
            tick();
            in_valid = 1'b0;
        end
        check("req_low_in_run", {31'b0, layer_req}, 32'd0);
        tick();
        check("req_high_after_run", {31'b0, layer_req}, 32'd1);
    endtask

    task automatic run_layer(input int l, input bit ack_with_wr, input bit junk);
        int t = 0;
        while (!layer_req && t < 50) begin
            tick();
            t++;
        end
        check("layer_req_rise", {31'b0, layer_req}, 32'd1);
        check("layer_sel", {31'b0, layer_sel}, 32'(l));
        if (junk) begin
            in_valid = 1'b1;
            in_data  = ~cur[0];
            start    = 1'b1;
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            check("req_hold_junk", {31'b0, layer_req}, 32'd1);
        end
        for (int i = 0; i < FANIN; i++) begin
            rd_trig = 1'b1;
            rd_addr = AW'(i);
            tick();
            rd_trig = 1'b0;
            check("rd_data", {24'b0, rd_data}, {24'b0, cur[i]});
            last_rd = cur[i];
        end
        for (int i = 0; i < FANIN; i++) nxt[i] = cur[i] + k_vec[l];
        // Descending order so the ack-coincident write targets index 0.
        for (int i = FANIN - 1; i >= 0; i--) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = nxt[i];
            if (i == 0 && ack_with_wr) layer_ack = 1'b1;
            tick();
            wr_en     = 1'b0;
            layer_ack = 1'b0;
        end
        if (!ack_with_wr) begin
            repeat (int'($urandom_range(0, 2))) tick();
            layer_ack = 1'b1;
            tick();
            layer_ack = 1'b0;
        end
        check("req_drop_on_ack", {31'b0, layer_req}, 32'd0);
        if (l == NUM_LAYERS - 1) check("out_valid_after_ack", {31'b0, out_valid}, 32'd1);
        cur = nxt;
    endtask

    task automatic drain(input bit bp);
        int t = 0;
        if (bp) begin
            repeat (5) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 8'hA5;
                tick();
                wr_en = 1'b0;
                check("bp_valid", {31'b0, out_valid}, 32'd1);
                check("bp_data", {24'b0, out_data}, {24'b0, exp_q[0]});
            end
        end
        while (exp_q.size() > 0 && t < 200) begin
            out_ready = bp ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        out_ready = 1'b0;
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic inference(input bit ack_wr_last, input bit junk, input bit bp);
        push_expected();
        cur = in_vec;
        do_start();
        load_vec(junk);
        for (int l = 0; l < NUM_LAYERS; l++) begin
            run_layer(l, (l == NUM_LAYERS - 1) ? ack_wr_last : 1'($urandom_range(0, 1)), junk);
        end
        drain(bp);
        exp_done++;
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("idle_after_done", {31'b0, busy}, 32'd0);
        rd_trig = 1'b1;
        rd_addr = '0;
        tick();
        rd_trig = 1'b0;
        check("rd_idle_hold", {24'b0, rd_data}, {24'b0, last_rd});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_layer_req", {31'b0, layer_req}, 32'd0);
        check("rst_layer_sel", {31'b0, layer_sel}, 32'd0);
        check("rst_rd_data", {24'b0, rd_data}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        tick();

        // Pass-through: +1 per layer, (5,-3) -> (7,-1).
        in_vec[0] = 8'd5;  in_vec[1] = 8'hFD;
        k_vec[0]  = 8'd1;  k_vec[1]  = 8'd1;
        inference(1'b0, 1'b0, 1'b0);

        // Read-port latency with (10,20).
        in_vec[0] = 8'd10; in_vec[1] = 8'd20;
        k_vec[0]  = 8'd3;  k_vec[1]  = 8'd7;
        inference(1'b0, 1'b0, 1'b0);

        // Backpressure plus ignored start/in_valid/layer_ack/wr_en.
        in_vec[0] = 8'h40; in_vec[1] = 8'h81;
        k_vec[0]  = 8'd2;  k_vec[1]  = 8'hFF;
        inference(1'b0, 1'b1, 1'b1);

        // Write coinciding with the final ack lands before the flip: first output 0x7F.
        in_vec[0] = 8'h7D; in_vec[1] = 8'h01;
        k_vec[0]  = 8'd1;  k_vec[1]  = 8'd1;
        inference(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in WAIT, mid-cycle.
        in_vec[0] = 8'h11; in_vec[1] = 8'h22;
        do_start();
        load_vec(1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_layer_req", {31'b0, layer_req}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        in_vec[0] = 8'h33; in_vec[1] = 8'hC4;
        k_vec[0]  = 8'd9;  k_vec[1]  = 8'd250;
        inference(1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < FANIN; i++) in_vec[i] = 8'($urandom);
            for (int l = 0; l < NUM_LAYERS; l++) k_vec[l] = 8'($urandom);
            inference(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_layer_scheduler.md
# nn_layer_scheduler

Sequencer for the fixed-point network datapath. It loads an input vector, runs each layer in turn through a shared request/acknowledge interface, and ping-pongs activations between two buffers. It then streams the final layer's outputs. It sits between the host-side stream and the layer blocks; each layer reads operands through a trigger/address read port and writes results back by index.

## Interface

Parameters:
- WIDTH, 8, activation word width (signed)
- FANIN, 2, activations per vector (layer fan-in = fan-out)
- NUM_LAYERS, 2, layers sequenced per inference
- AW, 1, index width, = max(1, clog2(FANIN))
- LW, 1, layer-select width, = max(1, clog2(NUM_LAYERS))

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin inference (sampled in IDLE only)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output accepted
- in_valid  in  1  input activation valid
- in_data  in  WIDTH  input activation, signed
- in_ready  out  1  scheduler accepts in_data
- layer_req  out  1  level request to the selected layer
- layer_sel  out  LW  index of layer being run
- layer_ack  in  1  selected layer finished (pulse or level)
- rd_trig  in  1  layer read strobe
- rd_addr  in  AW  layer read index
- rd_data  out  WIDTH  source-buffer word, registered
- wr_en  in  1  layer result write strobe
- wr_addr  in  AW  result index
- wr_data  in  WIDTH  result word
- out_valid  out  1  final activation valid
- out_data  out  WIDTH  final activation
- out_ready  in  1  downstream accepts out_data

## Operation

- Two buffers, A and B, each FANIN x WIDTH. A `src` bit selects the read buffer; the other buffer is the write buffer. `src` resets to A.
- States:
  - IDLE: start=1 -> LOAD, src=A, idx=0, layer_sel=0.
  - LOAD: in_ready=1. Each in_valid stores in_data into A[idx] and increments idx. On the FANIN-th word -> RUN, idx=0.
  - RUN: assert layer_req -> WAIT.
  - WAIT: layer_req held high. rd_trig returns src[rd_addr]; wr_en writes dst[wr_addr]. On layer_ack: drop layer_req, flip src.
    - If layer_sel == NUM_LAYERS-1 -> DRAIN, idx=0.
    - Else increment layer_sel -> RUN.
  - DRAIN: out_valid=1, out_data = src[idx]. On out_ready, idx increments. After the FANIN-th accepted word -> IDLE, with done pulse.
- busy = (state != IDLE).
- rd_trig and wr_en are honoured only in WAIT. In other states they are ignored, with no buffer write and no rd_data change.
- An index >= FANIN (non-power-of-two FANIN) is ignored: no write, and rd_data = 0.
- start outside IDLE is ignored. in_valid outside LOAD is ignored. layer_ack outside WAIT is ignored.
- Writes go only to the dst buffer, so same-cycle rd and wr never collide. Repeated writes to one index: the last write wins.
- Arithmetic: none on data. Counters wrap at FANIN/NUM_LAYERS boundaries as above, never past.

## Timing

- Reset (rst=0, asynchronous) sets: state IDLE, busy 0, done 0, in_ready 0, layer_req 0, layer_sel 0, rd_data 0, out_valid 0, out_data 0, src A, idx 0. Buffer contents are not reset.
- Reset mid-operation aborts immediately. No done pulse is issued, and layer_req drops the same instant.
- start accepted at edge t: busy=1 and in_ready=1 from t+1.
- LOAD takes exactly FANIN accepted beats; there are no bubbles inserted.
- After the last load beat at edge t, layer_req=1 from t+2 (one RUN cycle).
- rd_trig at edge t -> rd_data valid from t+1, held until the next honoured rd_trig.
- layer_ack at edge t -> layer_req=0 from t+1. If more layers remain, layer_req=1 again from t+2 with the new layer_sel.
- A write in the same cycle as layer_ack is committed before the flip.
- The first out_valid comes 1 cycle after the final layer_ack. Each out_ready advances one word per cycle.
- done pulses in the cycle after the last accepted output; busy falls together with done.
- Minimum inference (FANIN=2, NUM_LAYERS=2, immediate ack/ready) is about 10 cycles plus the layer latencies.

## Test plan

- Pass-through: FANIN=2, NUM_LAYERS=2. Load 5, -3. Layer model writes dst[i] = src[i]+1 then acks. Required outputs: 7, -1; one done pulse; layer_sel goes 0 then 1.
- Read-port latency: in WAIT, rd_trig with rd_addr=1 after loading (10, 20) -> rd_data=20 on the next cycle. rd_trig in IDLE -> rd_data unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_valid and out_data stable. Then ready pulses yield words in order; done follows only the second accept.
- Ignored events: start while busy, in_valid in WAIT, layer_ack in LOAD, wr_en in DRAIN -> no state, buffer, or output change.
- Simultaneous write+ack: wr_en to index 0 with value 0x7F in the same cycle as layer_ack on the final layer -> first output 0x7F.
- Async reset: drop rst in WAIT mid-clock -> layer_req and busy go to 0 without a clock edge. The next start runs cleanly from layer 0.
